// File: rtl/average_sliding_scheduler.sv
// Round-robin scheduler sharing one exponential sliding-average datapath
// between channel_count sample requesters, one accumulator per channel.
module average_sliding_scheduler #(
    parameter int channel_count             = 4,
    parameter int bitwidth_sample           = 12,
    parameter int shift                     = 4,
    parameter int initial_accumulator_value = 0
) (
    input  logic                                       trigger,
    input  logic                                       reset,
    input  logic [channel_count-1:0]                   request,
    input  logic [channel_count*bitwidth_sample-1:0]   sample_values,
    input  logic                                       flush,
    output logic [channel_count-1:0]                   grant,
    output logic [bitwidth_sample-1:0]                 averaged_value,
    output logic [$clog2(channel_count)-1:0]           averaged_channel,
    output logic                                       averaged_valid,
    output logic                                       busy
);

    localparam int cw = $clog2(channel_count);
    localparam int aw = bitwidth_sample + shift;
    localparam logic [aw-1:0] init_acc =
        aw'(initial_accumulator_value) << shift;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        EMIT
    } state_t;

    state_t                     state;
    state_t                     state_nx;
    logic [aw-1:0]              acc [channel_count];
    logic [bitwidth_sample-1:0] smp_in [channel_count];
    logic [bitwidth_sample-1:0] smp;
    logic [cw-1:0]              ptr;
    logic [cw-1:0]              idx;
    logic [cw-1:0]              pick;
    logic [cw:0]                cand;
    logic                       found;
    logic                       flush_pend;
    logic                       reload;

    assign reload = flush | flush_pend;
    assign busy   = (state != IDLE);

    always_comb begin
        for (int i = 0; i < channel_count; i++) begin
            smp_in[i] = sample_values[i*bitwidth_sample +: bitwidth_sample];
        end
    end

    // Search starts just after the last served channel, wrapping once.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= channel_count; i++) begin
            cand = {1'b0, ptr} + (cw+1)'(i);
            if (cand >= (cw+1)'(channel_count)) begin
                cand = cand - (cw+1)'(channel_count);
            end
            if (!found && request[cand[cw-1:0]]) begin
                found = 1'b1;
                pick  = cand[cw-1:0];
            end
        end
    end

    always_ff @(posedge trigger or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (!reload && found) state_nx = UPDATE;
            UPDATE:  state_nx = EMIT;
            EMIT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge trigger or negedge reset) begin
        if (!reset) begin
            grant            <= '0;
            averaged_value   <= '0;
            averaged_channel <= '0;
            averaged_valid   <= 1'b0;
            ptr              <= cw'(channel_count - 1);
            idx              <= '0;
            smp              <= '0;
            flush_pend       <= 1'b0;
            for (int i = 0; i < channel_count; i++) begin
                acc[i] <= init_acc;
            end
        end else begin
            grant          <= '0;
            averaged_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (reload) begin
                        for (int i = 0; i < channel_count; i++) begin
                            acc[i] <= init_acc;
                        end
                        flush_pend <= 1'b0;
                    end else if (found) begin
                        idx         <= pick;
                        smp         <= smp_in[pick];
                        grant[pick] <= 1'b1;
                    end
                end
                UPDATE: begin
                    // Bounded by (2**b-1)<<shift, so aw bits never wrap.
                    acc[idx] <= acc[idx] - (acc[idx] >> shift) + aw'(smp);
                    if (flush) flush_pend <= 1'b1;
                end
                EMIT: begin
                    averaged_value   <= bitwidth_sample'(acc[idx] >> shift);
                    averaged_channel <= idx;
                    averaged_valid   <= 1'b1;
                    ptr              <= idx;
                    if (flush) flush_pend <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_average_sliding_scheduler.sv
// Scoreboard bench for average_sliding_scheduler: a transaction-level
// model predicts grants and averages, a monitor checks DUT outputs.
module tb_average_sliding_scheduler;

    localparam int N  = 4;
    localparam int B  = 12;
    localparam int SH = 4;
    localparam int CW = 2;

    logic           trigger = 1'b0;
    logic           reset   = 1'b0;
    logic [N-1:0]   request = '0;
    logic [N*B-1:0] sample_values = '0;
    logic           flush = 1'b0;
    logic [N-1:0]   grant;
    logic [B-1:0]   averaged_value;
    logic [CW-1:0]  averaged_channel;
    logic           averaged_valid;
    logic           busy;

    logic           reset2 = 1'b0;
    logic [N-1:0]   request2 = '0;
    logic [N*B-1:0] sv2 = '0;
    logic           flush2 = 1'b0;
    logic [N-1:0]   grant2;
    logic [B-1:0]   val2;
    logic [CW-1:0]  ch2;
    logic           valid2;
    logic           busy2;

    average_sliding_scheduler #(
        .channel_count(N), .bitwidth_sample(B), .shift(SH),
        .initial_accumulator_value(0)
    ) dut (
        .trigger(trigger), .reset(reset), .request(request),
        .sample_values(sample_values), .flush(flush), .grant(grant),
        .averaged_value(averaged_value), .averaged_channel(averaged_channel),
        .averaged_valid(averaged_valid), .busy(busy)
    );

    average_sliding_scheduler #(
        .channel_count(N), .bitwidth_sample(B), .shift(SH),
        .initial_accumulator_value(100)
    ) dut2 (
        .trigger(trigger), .reset(reset2), .request(request2),
        .sample_values(sv2), .flush(flush2), .grant(grant2),
        .averaged_value(val2), .averaged_channel(ch2),
        .averaged_valid(valid2), .busy(busy2)
    );

    always #5 trigger = ~trigger;

    typedef struct {
        int ch;
        int val;
    } exp_t;

    exp_t eq[$];
    int   gq[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   valid_cnt  = 0;

    int   macc [N];
    int   mptr;
    int   hold;
    bit   mpend;
    bit   exp_busy;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        vectors++;
        miscompares++;
        $display("FAIL %s", msg);
    endtask

    // Reference: a served sample makes the unit unavailable for two more
    // edges; flushes arriving then are remembered and applied when free.
    always @(posedge trigger or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) macc[i] = 0;
            mptr = N - 1;
            hold = 0;
            mpend = 0;
            exp_busy = 0;
            eq.delete();
            gq.delete();
        end else if (hold > 0) begin
            if (flush) mpend = 1;
            hold--;
            exp_busy = (hold > 0);
        end else if (flush || mpend) begin
            for (int i = 0; i < N; i++) macc[i] = 0;
            mpend = 0;
        end else begin
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (mptr + i) % N;
                if (request[c]) begin
                    int s;
                    s = int'(sample_values[c*B +: B]);
                    macc[c] = macc[c] - macc[c] / (2 ** SH) + s;
                    eq.push_back('{c, macc[c] / (2 ** SH)});
                    gq.push_back(c);
                    mptr = c;
                    hold = 2;
                    exp_busy = 1;
                    break;
                end
            end
        end
    end

    always @(negedge trigger) begin
        if (reset) begin
            if (grant != '0) begin
                if (gq.size() == 0) begin
                    fail_now($sformatf("grant_unexpected: got %b expected none",
                                       grant));
                end else begin
                    int g;
                    g = gq.pop_front();
                    chk("grant", 32'(grant), 32'(1) << g);
                end
            end
            if (averaged_valid) begin
                valid_cnt++;
                if (eq.size() == 0) begin
                    fail_now($sformatf("valid_unexpected: got ch %0d val %0d",
                                       averaged_channel, averaged_value));
                end else begin
                    exp_t e;
                    e = eq.pop_front();
                    chk("avg_channel", 32'(averaged_channel), 32'(e.ch));
                    chk("avg_value", 32'(averaged_value), 32'(e.val));
                end
            end
            chk("busy", 32'(busy), 32'(exp_busy));
        end
    end

    task automatic wait_valids(input int n, input string name);
        int start;
        int cyc;
        start = valid_cnt;
        cyc = 0;
        while (valid_cnt < start + n && cyc < n * 3 + 40) begin
            @(negedge trigger);
            cyc++;
        end
        if (valid_cnt < start + n) begin
            fail_now($sformatf("%s timeout: got %0d results expected %0d",
                               name, valid_cnt - start, n));
        end
    endtask

    task automatic wait_grant(input string name);
        int cyc;
        cyc = 0;
        @(negedge trigger);
        while (grant == '0 && cyc < 20) begin
            @(negedge trigger);
            cyc++;
        end
        if (grant == '0) fail_now($sformatf("%s timeout: no grant", name));
    endtask

    task automatic drain();
        request = '0;
        flush = 1'b0;
        repeat (8) @(negedge trigger);
    endtask

    initial begin
        repeat (3) @(negedge trigger);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(averaged_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_value", 32'(averaged_value), 0);
        chk("rst_channel", 32'(averaged_channel), 0);
        reset = 1'b1;
        @(negedge trigger);

        // Channel 0 constant 256 converges to 256
        flush = 1'b1;
        @(negedge trigger);
        flush = 1'b0;
        sample_values[0 +: B] = 12'd256;
        request = 4'b0001;
        wait_valids(1, "first256");
        chk("first256", 32'(averaged_value), 16);
        wait_valids(1, "second256");
        chk("second256", 32'(averaged_value), 31);
        wait_valids(148, "settle256");
        chk("settled256", 32'(averaged_value), 256);
        drain();

        // All channels requesting: strict rotation
        for (int c = 0; c < N; c++) sample_values[c*B +: B] = B'($urandom);
        request = '1;
        wait_valids(12, "rotation");
        drain();

        // Randomised traffic with occasional flushes
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge trigger);
            flush = ($urandom_range(0, 29) == 0);
            for (int c = 0; c < N; c++) begin
                if (grant[c]) begin
                    request[c] = 1'b0;
                end else if (!request[c] && $urandom_range(0, 2) == 0) begin
                    sample_values[c*B +: B] = B'($urandom);
                    request[c] = 1'b1;
                end
            end
        end
        drain();

        // Asynchronous reset while an update is in flight
        sample_values[0 +: B] = 12'd777;
        request = 4'b0001;
        wait_grant("pre_reset");
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_valid", 32'(averaged_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_value", 32'(averaged_value), 0);
        request = '1;
        for (int c = 0; c < N; c++) sample_values[c*B +: B] = B'($urandom);
        repeat (2) @(negedge trigger);
        chk("held_rst_valid", 32'(averaged_valid), 0);
        #2;
        reset = 1'b1;
        wait_grant("post_reset");
        chk("post_rst_first", 32'(grant), 1);
        wait_valids(6, "post_reset");
        drain();

        // Full-scale input settles without wrapping
        flush = 1'b1;
        @(negedge trigger);
        flush = 1'b0;
        sample_values[0 +: B] = 12'd4095;
        request = 4'b0001;
        wait_valids(250, "fullscale");
        chk("fullscale", 32'(averaged_value), 4095);
        drain();

        // Non-zero initial value decays toward zero samples
        reset2 = 1'b1;
        request2 = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            int cyc;
            cyc = 0;
            @(negedge trigger);
            while (!valid2 && cyc < 20) begin
                @(negedge trigger);
                cyc++;
            end
            if (!valid2) begin
                fail_now("init100 timeout: no valid");
            end else begin
                chk("init100_value", 32'(val2), (k == 0) ? 93 : 87);
                chk("init100_channel", 32'(ch2), 0);
            end
        end
        request2 = '0;

        chk("eq_empty", 32'(eq.size()), 0);
        chk("gq_empty", 32'(gq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
